// File: rtl/root_pkg.sv
// root_pkg: shared types and helpers for the RootProcess XOUT accumulator.
//   state_e    - accumulator FSM states (ACCUM, HOLD)
//   NBITS_DEF  - default sample width (matches RootProcess XOUT)
//   root_rec_t - block result record (sum, min, max, count), sized wide
//                enough for any legal parameterisation of the stage
//   umin/umax  - unsigned min/max helpers
package root_pkg;

  localparam int unsigned NBITS_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned REC_SUM_W = 32;
  localparam int unsigned REC_VAL_W = 16;
  localparam int unsigned REC_CNT_W = 16;

  typedef struct packed {
    logic [REC_SUM_W-1:0] sum;
    logic [REC_VAL_W-1:0] min;
    logic [REC_VAL_W-1:0] max;
    logic [REC_CNT_W-1:0] count;
  } root_rec_t;

  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/root_minmax_track.sv
// root_minmax_track: running unsigned min/max of a sample stream.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : return the tracker to its empty state (min=all-ones, max=0)
//   upd_i        : fold x_i into the running min/max
//   x_i          : sample
//   min_o, max_o : running min/max including this cycle's update (combinational)
module root_minmax_track
  import root_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [NBITS-1:0] x_i,
  output logic [NBITS-1:0] min_o,
  output logic [NBITS-1:0] max_o
);

  logic [NBITS-1:0] min_q, max_q;
  logic [NBITS-1:0] min_d, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (upd_i) begin
      min_d = NBITS'(umin(32'(min_q), 32'(x_i)));
      max_d = NBITS'(umax(32'(max_q), 32'(x_i)));
    end
  end

  // The caller captures min_o/max_o on the clearing cycle, so the
  // updated value is exposed even though the registers are being cleared.
  assign min_o = min_d;
  assign max_o = max_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clr_i) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/root_xout_accum.sv
// root_xout_accum: reduces blocks of NSAMPLES unsigned XOUT samples to a
// registered (sum, min, max, count) record; FLUSH closes a partial block.
//   CLK, RST              : clock, asynchronous active-high reset
//   XIN/XIN_VALID/XIN_READY : sample stream in (ready only in ACCUM)
//   FLUSH                 : close the current non-empty block
//   SUM_OUT/MIN_OUT/MAX_OUT/COUNT_OUT : result record
//   OUT_VALID/OUT_READY   : result handshake (valid only in HOLD)
module root_xout_accum
  import root_pkg::*;
#(
  parameter int unsigned NBITS    = NBITS_DEF,
  parameter int unsigned NSAMPLES = 16
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NBITS-1:0]                     XIN,
  input  logic                                 XIN_VALID,
  output logic                                 XIN_READY,
  input  logic                                 FLUSH,
  output logic [NBITS+$clog2(NSAMPLES)-1:0]    SUM_OUT,
  output logic [NBITS-1:0]                     MIN_OUT,
  output logic [NBITS-1:0]                     MAX_OUT,
  output logic [$clog2(NSAMPLES+1)-1:0]        COUNT_OUT,
  output logic                                 OUT_VALID,
  input  logic                                 OUT_READY
);

  localparam int unsigned SBITS = NBITS + $clog2(NSAMPLES);
  localparam int unsigned CBITS = $clog2(NSAMPLES + 1);
  localparam logic [CBITS-1:0] LAST_CNT = CBITS'(NSAMPLES - 1);

  state_e           state_q;
  logic [SBITS-1:0] sum_q, sum_d, sum_out_q;
  logic [CBITS-1:0] cnt_q, cnt_d, cnt_out_q;
  logic [NBITS-1:0] min_d, max_d, min_out_q, max_out_q;
  logic             in_rdy, accept, close;

  // RST gates ready so the producer sees a stalled stage during reset.
  assign in_rdy = (state_q == ACCUM) && !RST;
  assign accept = XIN_VALID && in_rdy;

  assign sum_d = sum_q + (accept ? SBITS'(XIN) : '0);
  assign cnt_d = cnt_q + {{(CBITS-1){1'b0}}, accept};

  assign close = (state_q == ACCUM) &&
                 ((accept && (cnt_q == LAST_CNT)) ||
                  (FLUSH && ((cnt_q != '0) || accept)));

  root_minmax_track #(
    .NBITS(NBITS)
  ) u_minmax (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (close),
    .upd_i (accept),
    .x_i   (XIN),
    .min_o (min_d),
    .max_o (max_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cnt_out_q <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (close) begin
            sum_out_q <= sum_d;
            cnt_out_q <= cnt_d;
            min_out_q <= min_d;
            max_out_q <= max_d;
            sum_q     <= '0;
            cnt_q     <= '0;
            state_q   <= HOLD;
          end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (OUT_READY) state_q <= ACCUM;
        end
      endcase
    end
  end

  assign XIN_READY = in_rdy;
  assign OUT_VALID = (state_q == HOLD);
  assign SUM_OUT   = sum_out_q;
  assign MIN_OUT   = min_out_q;
  assign MAX_OUT   = max_out_q;
  assign COUNT_OUT = cnt_out_q;

endmodule

// File: tb/tb_root_xout_accum.sv
module tb_root_xout_accum;
  import root_pkg::*;

  localparam int NS = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] XIN = '0;
  logic       XIN_VALID = 1'b0;
  logic       XIN_READY;
  logic       FLUSH = 1'b0;
  logic [9:0] SUM_OUT;
  logic [7:0] MIN_OUT;
  logic [7:0] MAX_OUT;
  logic [2:0] COUNT_OUT;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;

  root_xout_accum #(
    .NBITS   (8),
    .NSAMPLES(NS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .XIN       (XIN),
    .XIN_VALID (XIN_VALID),
    .XIN_READY (XIN_READY),
    .FLUSH     (FLUSH),
    .SUM_OUT   (SUM_OUT),
    .MIN_OUT   (MIN_OUT),
    .MAX_OUT   (MAX_OUT),
    .COUNT_OUT (COUNT_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples of the open block, pending expected records,
  // and whether a record is waiting for the sink.
  int        blk[$];
  root_rec_t expq[$];
  bit        m_hold = 1'b0;
  bit        m_acc  = 1'b0;
  int        n_blocks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    blk.delete();
    expq.delete();
    m_hold = 1'b0;
  endtask

  // Applies the rules for the edge about to happen, given current inputs.
  task automatic model_step();
    root_rec_t e;
    int s, mn, mx;
    m_acc = 1'b0;
    if (m_hold) begin
      if (OUT_READY) m_hold = 1'b0;
    end else begin
      if (XIN_VALID) begin
        blk.push_back(int'(XIN));
        m_acc = 1'b1;
      end
      if (blk.size() == NS || (FLUSH && blk.size() > 0)) begin
        s = 0; mn = 255; mx = 0;
        foreach (blk[i]) begin
          s += blk[i];
          if (blk[i] < mn) mn = blk[i];
          if (blk[i] > mx) mx = blk[i];
        end
        e.sum   = 32'(s);
        e.min   = 16'(mn);
        e.max   = 16'(mx);
        e.count = 16'(blk.size());
        expq.push_back(e);
        blk.delete();
        m_hold = 1'b1;
        n_blocks++;
      end
    end
  endtask

  // One cycle: drive inputs, check handshake signals, advance the model.
  task automatic cyc(input logic v, input logic [7:0] x, input logic fl, input logic ordy);
    XIN_VALID = v; XIN = x; FLUSH = fl; OUT_READY = ordy;
    @(negedge CLK);
    chk("xin_ready", int'(XIN_READY), int'(!m_hold));
    chk("out_valid", int'(OUT_VALID), int'(m_hold));
    model_step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] x, input logic fl, input logic ordy);
    int tries = 0;
    do begin
      cyc(1'b1, x, fl, ordy);
      tries++;
    end while (!m_acc && tries < 50);
    if (!m_acc) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    RST = 1'b1; XIN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("rst_xin_ready", int'(XIN_READY), 0);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_sum", int'(SUM_OUT), 0);
    chk("rst_min", int'(MIN_OUT), 0);
    chk("rst_max", int'(MAX_OUT), 0);
    chk("rst_count", int'(COUNT_OUT), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Monitor: pops one expected record per output handshake, and checks
  // that a stalled record does not change while the sink is not ready.
  logic [28:0] held;
  bit          held_v = 1'b0;
  always @(negedge CLK) begin
    root_rec_t e, a;
    if (RST) begin
      held_v = 1'b0;
    end else begin
      if (OUT_VALID && held_v) begin
        n_cmp++;
        if ({SUM_OUT, MIN_OUT, MAX_OUT, COUNT_OUT} !== held) begin
          n_bad++;
          $display("FAIL out_stable: got %h expected %h", {SUM_OUT, MIN_OUT, MAX_OUT, COUNT_OUT}, held);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_record: got sum=%0d with no record expected", SUM_OUT);
        end else begin
          e = expq.pop_front();
          a.sum = 32'(SUM_OUT); a.min = 16'(MIN_OUT);
          a.max = 16'(MAX_OUT); a.count = 16'(COUNT_OUT);
          if (a !== e) begin
            n_bad++;
            $display("FAIL record: got sum=%0d min=%0d max=%0d cnt=%0d expected sum=%0d min=%0d max=%0d cnt=%0d",
                     a.sum, a.min, a.max, a.count, e.sum, e.min, e.max, e.count);
          end
        end
        held_v = 1'b0;
      end else if (OUT_VALID) begin
        held   = {SUM_OUT, MIN_OUT, MAX_OUT, COUNT_OUT};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int target, cycles, drain;
    do_reset();

    // Mixed block: 262 / 3 / 200 / 4.
    send(8'd49, 1'b0, 1'b1); send(8'd10, 1'b0, 1'b1);
    send(8'd200, 1'b0, 1'b1); send(8'd3, 1'b0, 1'b1);
    // Wrap value and full-scale block: no overflow in the sum.
    repeat (NS) send(8'd235, 1'b0, 1'b1);
    repeat (NS) send(8'd255, 1'b0, 1'b1);

    // Flush together with the third sample, then a flush on an empty block.
    send(8'd7, 1'b0, 1'b1); send(8'd9, 1'b0, 1'b1); send(8'd5, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // Back-pressure: sink stalls for 10 cycles while the producer pushes.
    send(8'd11, 1'b0, 1'b0); send(8'd22, 1'b0, 1'b0);
    send(8'd33, 1'b0, 1'b0); send(8'd44, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 8'd55, 1'b1, 1'b0);
    send(8'd55, 1'b0, 1'b1); send(8'd56, 1'b0, 1'b1);
    send(8'd57, 1'b0, 1'b1); send(8'd58, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-block discards the partial block.
    send(8'd90, 1'b0, 1'b1); send(8'd91, 1'b0, 1'b1); send(8'd92, 1'b0, 1'b1);
    do_reset();
    send(8'd1, 1'b0, 1'b1); send(8'd2, 1'b0, 1'b1);
    send(8'd3, 1'b0, 1'b1); send(8'd4, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 8'd0, 1'b0, 1'b1);

    // Random valid/ready/flush over 1000 blocks.
    target = n_blocks + 1000;
    cycles = 0;
    while (n_blocks < target && cycles < 40000) begin
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6));
      cycles++;
    end
    if (n_blocks < target) chk("random_blocks_timeout", n_blocks, target);

    drain = 0;
    while ((m_hold || expq.size() != 0) && drain < 20) begin
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      drain++;
    end
    repeat (2) cyc(1'b0, 8'd0, 1'b0, 1'b1);
    chk("records_outstanding", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
